// File: rtl/mult_div_unit_if.sv
// Handshake and operand/result bundle between the control unit and the
// iterative multiply/divide unit.
interface mult_div_unit_if;
    logic        start;
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    // Control unit side: issues requests, reads status and HI/LO.
    modport master (
        output start, op, a, b,
        input  busy, done, div_zero, hi, lo
    );

    // Unit side: accepts requests, produces status and HI/LO.
    modport slave (
        input  start, op, a, b,
        output busy, done, div_zero, hi, lo
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative signed multiply/divide unit holding the HI/LO registers.
// Both operations work on magnitudes for 32 cycles and apply the sign
// correction in a single FINISH cycle. All outputs are registered.
module mult_div_unit (
    input  logic            clk,
    input  logic            reset,
    mult_div_unit_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [5:0]  count_q;
    logic        op_q;
    logic        sign_a_q;
    logic        sign_b_q;
    logic        dz_q;
    logic [31:0] mag_a_q;
    logic [31:0] mag_b_q;
    // Multiply: full 64-bit accumulator, low half doubles as the multiplier
    // shift register. Divide: low half is the dividend/quotient shift register.
    logic [63:0] acc_q;
    logic [32:0] rem_q;

    logic        busy_q;
    logic        done_q;
    logic        div_zero_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    logic        busy_d;
    logic        done_d;
    logic        div_zero_d;
    logic        write_d;
    logic        accept;
    logic        is_div_zero;

    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [32:0] mul_sum;
    logic [32:0] div_shift;
    logic [32:0] div_diff;
    logic        div_fits;
    logic        neg_result;
    logic [63:0] prod_fix;
    logic [31:0] quot_fix;
    logic [31:0] rem_fix;

    // Operand magnitudes; -0x80000000 wraps back to 0x80000000, which is the
    // correct unsigned magnitude.
    assign abs_a       = bus.a[31] ? (32'd0 - bus.a) : bus.a;
    assign abs_b       = bus.b[31] ? (32'd0 - bus.b) : bus.b;
    assign accept      = (state_q == IDLE) && bus.start;
    assign is_div_zero = bus.op && (bus.b == 32'd0);

    // One shift-add step: add the multiplicand when the current multiplier
    // bit is set, carry lands in bit 32 before the right shift.
    assign mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, mag_a_q} : 33'd0);

    // One restoring step: bring in the next dividend bit, subtract if it fits.
    assign div_shift = {rem_q[31:0], acc_q[31]};
    assign div_diff  = div_shift - {1'b0, mag_b_q};
    assign div_fits  = (div_shift >= {1'b0, mag_b_q});

    // Sign correction applied on the way into HI/LO.
    assign neg_result = sign_a_q ^ sign_b_q;
    assign prod_fix   = neg_result ? (64'd0 - acc_q) : acc_q;
    assign quot_fix   = neg_result ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
    assign rem_fix    = sign_a_q ? (32'd0 - rem_q[31:0]) : rem_q[31:0];

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = is_div_zero ? FINISH : RUN;
            RUN:     if (count_q == 6'd31) state_d = FINISH;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d     = (state_d != IDLE);
        done_d     = (state_q == FINISH);
        div_zero_d = (state_q == FINISH) && dz_q;
        write_d    = (state_q == FINISH) && !dz_q;
    end

    // Operand capture and iteration datapath.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q  <= 6'd0;
            op_q     <= 1'b0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            dz_q     <= 1'b0;
            mag_a_q  <= 32'd0;
            mag_b_q  <= 32'd0;
            acc_q    <= 64'd0;
            rem_q    <= 33'd0;
        end else if (accept) begin
            count_q  <= 6'd0;
            op_q     <= bus.op;
            sign_a_q <= bus.a[31];
            sign_b_q <= bus.b[31];
            dz_q     <= is_div_zero;
            mag_a_q  <= abs_a;
            mag_b_q  <= abs_b;
            acc_q    <= {32'd0, bus.op ? abs_a : abs_b};
            rem_q    <= 33'd0;
        end else if (state_q == RUN) begin
            count_q <= count_q + 6'd1;
            if (!op_q) begin
                acc_q <= {mul_sum, acc_q[31:1]};
            end else begin
                rem_q        <= div_fits ? div_diff : div_shift;
                acc_q[31:0]  <= {acc_q[30:0], div_fits};
            end
        end
    end

    // Registered status and HI/LO outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
        end else begin
            busy_q     <= busy_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
            if (write_d) begin
                hi_q <= op_q ? rem_fix  : prod_fix[63:32];
                lo_q <= op_q ? quot_fix : prod_fix[31:0];
            end
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.div_zero = div_zero_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;

endmodule
